if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Instruction-fetch stage between the program counter and decode. Each cycle it turns the PC stage's `curr_pc` into an instruction-memory request. It pairs each returned word with its PC and buffers the pairs in a small queue feeding decode over a valid/ready handshake. It drives `pc_hazarded` back to the PC stage when a request cannot be accepted. It squashes all queued and in-flight fetches on `pipelineFlush`.

## Interface
- `DEPTH`, 2: queue entries; also the cap on in-flight requests (power of two, ≥2)
- `clk` input 1: clock, rising edge
- `rst` input 1: reset, asynchronous, active-low
- `curr_pc` input `instWidth`: fetch address from PC stage
- `pipelineFlush` input 1: redirect; `curr_pc` already holds the target this cycle
- `pc_hazarded` output 1: PC must hold; combinational
- `imem_req` output 1: request valid
- `imem_addr` output `instWidth`: equals `curr_pc`
- `imem_gnt` input 1: request accepted this cycle
- `imem_rvalid` input 1: response valid; never in the same cycle as its own grant
- `imem_rdata` input `instWidth`: response word, in order
- `id_valid` output 1: decode entry valid
- `id_ready` input 1: decode accepts
- `id_pc` output `instWidth`: PC of head entry
- `id_inst` output `instWidth`: instruction of head entry

## Operation
- State:
  - `outstanding`: granted requests not yet returned.
  - `pc_track`: an in-order FIFO of PCs for in-flight requests, DEPTH deep.
  - `occ`: queue occupancy.
  - `drop`: responses still to discard.
- Credit:
  - `used = outstanding + occ − (id_valid & id_ready)`.
  - A request is allowed iff `used < DEPTH`.
  - On a flush cycle, `occ` counts as 0.
- `imem_req = credit`. A grant pushes `curr_pc` into `pc_track` and increments `outstanding`.
- `pc_hazarded = !(imem_req & imem_gnt)`.
- Response handling:
  - A response pops `pc_track` and decrements `outstanding`.
  - If `drop == 0`, `{pc, rdata}` is written to the queue.
  - Otherwise the response is discarded and `drop` decrements.
- Flush cycle:
  - Queue cleared; `id_valid` is 0 from the next cycle.
  - `drop` is set to `outstanding` minus any response arriving this same cycle. That response is itself discarded.
  - A grant in the flush cycle is for the target and is kept, not dropped.
- A flush held for several cycles is idempotent. Each cycle re-clears the queue and recomputes `drop`, excluding grants taken during the flush.
- Simultaneous push and pop on a full queue is legal; occupancy is unchanged.
- Overflow is impossible by the credit rule. A push on a full queue is an assertion failure.
- Decode handshake: an entry transfers on `id_valid & id_ready`. Head contents stay stable while `id_valid & !id_ready`.

## Timing
- Reset values (async, while `rst` low):
  - `imem_req`=0, `pc_hazarded`=1, `id_valid`=0.
  - `id_pc`=`zeroWord`, `id_inst`=`zeroWord` (`nopInst` if `IF_NOP_INJECT_EN`).
  - `outstanding`, `occ`, `drop` = 0.
- Reset mid-operation abandons all state. Responses to pre-reset grants are the memory's responsibility; the memory is reset together with this block.
- Latency: a response in cycle N gives `id_valid` in cycle N+1 (registered queue). Grant-to-decode is therefore memory latency + 1.
- With 1-cycle memory, always-granting, and `id_ready`=1: one instruction per cycle sustained at `DEPTH`=2. `pc_hazarded` stays 0 after the first fetch.
- `imem_req` and `pc_hazarded` depend combinationally on `id_ready`. There is no combinational path from `imem_rvalid` to any output.

## Configuration
- `IF_NOP_INJECT_EN`:
  - Defined: when `id_valid`=0, `id_inst` reads `nopInst` (32'h00000013) and `id_pc` reads `zeroWord`.
  - Undefined: outputs hold the last head value when invalid.
- Handshake and credit behaviour are identical either way.

## Structure
- Shared `define.v` holds `instWidth`, `zeroWord`, `funEnable`/`funDisable`, and the new `nopInst`.
- One sub-module, `fetch_fifo`: a synchronous parameterised FIFO with async active-low reset and a synchronous clear. It is instantiated twice: as the `{pc, inst}` queue and as `pc_track`.

## Test plan
- Reset, then 1-cycle memory, `id_ready`=1, PC 0x0,0x4,0x8… → `id_valid` first rises at cycle 2 with `id_pc`=0x0. One entry per cycle follows; `pc_hazarded`=0 from cycle 1.
- `id_ready`=0 for 5 cycles → at most 2 outstanding+queued. `pc_hazarded`=1 and head `id_pc` stable. Resume returns PCs in order with none lost.
- Flush redirect to 0x100 with 2 requests in flight → both stale responses discarded. Next decoded `id_pc`=0x100.
- Flush coincident with a stale `imem_rvalid` and a target grant → stale word dropped, target word delivered, `drop` ends at 0.
- `imem_gnt` withheld 3 cycles → `pc_hazarded`=1 those cycles and `curr_pc` held. The grant then issues the same address once.
- `rst` asserted mid-stream with queue full → `id_valid`=0 immediately (async). `id_inst`=0x00000013 with `IF_NOP_INJECT_EN`, else 0x0.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// rtl/if_fetch_queue_pkg.sv - shared widths, constant words and entry type for the fetch queue
package if_fetch_queue_pkg;

    localparam int instWidth = 32;
    localparam logic [instWidth-1:0] zeroWord = '0;
    localparam logic funEnable  = 1'b1;
    localparam logic funDisable = 1'b0;
    localparam logic [instWidth-1:0] nopInst = 32'h00000013;

    typedef struct packed {
        logic [instWidth-1:0] pc;
        logic [instWidth-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// rtl/if_fetch_queue_fetch_fifo.sv - synchronous FIFO with async reset and synchronous clear
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && w_full && !w_do_pop && !i_clear));

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch stage: credit-limited imem requests, PC pairing, decode queue, flush squash
// Optional IF_NOP_INJECT_EN: invalid head reads nopInst/zeroWord instead of holding the last head.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [instWidth-1:0] curr_pc,
    input  logic                 pipelineFlush,
    output logic                 pc_hazarded,
    output logic                 imem_req,
    output logic [instWidth-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [instWidth-1:0] imem_rdata,
    output logic                 id_valid,
    input  logic                 id_ready,
    output logic [instWidth-1:0] id_pc,
    output logic [instWidth-1:0] id_inst
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 2 * instWidth;

    logic [CW-1:0]        w_outstanding;
    logic [CW-1:0]        w_occ;
    logic [CW-1:0]        w_drop_base;
    logic [CW-1:0]        r_drop;
    logic                 r_flush_q;
    logic [CW:0]          w_used;
    logic                 w_credit;
    logic                 w_grant;
    logic                 w_pop;
    logic                 w_q_push;
    logic                 w_valid;
    logic [instWidth-1:0] w_track_pc;
    fetch_entry_t         w_head;

    assign w_valid = (w_occ != '0);
    assign w_pop   = w_valid & id_ready;

    // in-flight plus queued entries must fit the queue; a flush empties the queue this cycle
    always_comb begin
        w_used = {1'b0, w_outstanding};
        if (!pipelineFlush) begin
            w_used = w_used + {1'b0, w_occ} - (CW+1)'(w_pop);
        end
    end

    assign w_credit    = (w_used < (CW+1)'(DEPTH));
    assign imem_req    = rst & w_credit;
    assign imem_addr   = curr_pc;
    assign w_grant     = imem_req & imem_gnt;
    assign pc_hazarded = ~w_grant;

    assign w_q_push = imem_rvalid & (r_drop == '0) & ~pipelineFlush;

    // outstanding request count is the pc_track occupancy
    fetch_fifo #(
        .WIDTH (instWidth),
        .DEPTH (DEPTH)
    ) u_pc_track (
        .clk     (clk),
        .rst_n   (rst),
        .i_clear (1'b0),
        .i_push  (w_grant),
        .i_data  (curr_pc),
        .i_pop   (imem_rvalid),
        .o_head  (w_track_pc),
        .o_count (w_outstanding)
    );

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst),
        .i_clear (pipelineFlush),
        .i_push  (w_q_push),
        .i_data  ({w_track_pc, imem_rdata}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_occ)
    );

    // a held flush keeps the stale count from its first cycle so grants taken during it survive
    assign w_drop_base = r_flush_q ? r_drop : w_outstanding;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop    <= '0;
            r_flush_q <= 1'b0;
        end else begin
            r_flush_q <= pipelineFlush;
            if (pipelineFlush) begin
                r_drop <= w_drop_base - CW'(imem_rvalid && (w_drop_base != '0));
            end else if (imem_rvalid && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
        end
    end

    assign id_valid = w_valid;

`ifdef IF_NOP_INJECT_EN
    assign id_pc   = w_valid ? w_head.pc   : zeroWord;
    assign id_inst = w_valid ? w_head.inst : nopInst;
`else
    logic [instWidth-1:0] r_hold_pc;
    logic [instWidth-1:0] r_hold_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_pc   <= zeroWord;
            r_hold_inst <= zeroWord;
        end else if (w_valid) begin
            r_hold_pc   <= w_head.pc;
            r_hold_inst <= w_head.inst;
        end
    end

    assign id_pc   = w_valid ? w_head.pc   : r_hold_pc;
    assign id_inst = w_valid ? w_head.inst : r_hold_inst;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed bench with queue-level reference model for if_fetch_queue
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] curr_pc;
    logic        pipelineFlush;
    logic        pc_hazarded;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .curr_pc       (curr_pc),
        .pipelineFlush (pipelineFlush),
        .pc_hazarded   (pc_hazarded),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_inst       (id_inst)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [32:0] m_fly[$];
    logic [63:0] m_q[$];
    logic [31:0] m_mem[$];
    int          m_due[$];
    logic [31:0] m_last_pc;
    logic [31:0] m_last_inst;
    logic        m_prev_flush;

    int          lat;
    logic        gnt_en;
    logic        rdy;
    logic        fl;
    logic [31:0] fl_tgt;
    logic [31:0] pc_reg;

    logic        watch;
    int          first_cyc;
    logic [31:0] first_pc;
    logic [31:0] first_inst;
    int          haz_cnt;
    logic        last_haz;
    logic [31:0] last_id_pc;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return pc + 32'h1000_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_fly.delete();
        m_q.delete();
        m_mem.delete();
        m_due.delete();
        m_last_pc    = 32'h0;
        m_last_inst  = 32'h0;
        m_prev_flush = 1'b0;
        pc_reg       = 32'h0;
    endtask

    // one clock cycle: drive at posedge+1, check at negedge, advance model at posedge
    task automatic cycle();
        logic        ev;
        logic        pop;
        logic        ereq;
        logic        ehaz;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [32:0] e;
        int          used;
        pipelineFlush = fl;
        if (fl) pc_reg = fl_tgt;
        curr_pc     = pc_reg;
        imem_gnt    = gnt_en;
        id_ready    = rdy;
        imem_rvalid = (m_due.size() > 0) && (m_due[0] <= cyc);
        imem_rdata  = imem_rvalid ? m_mem[0] : 32'hDEAD_BEEF;
        @(negedge clk);
        ev = (m_q.size() > 0);
        if (ev) begin
            {epc, einst} = m_q[0];
        end else begin
`ifdef IF_NOP_INJECT_EN
            epc   = 32'h0;
            einst = 32'h0000_0013;
`else
            epc   = m_last_pc;
            einst = m_last_inst;
`endif
        end
        pop  = ev && rdy;
        used = fl ? m_fly.size() : m_fly.size() + m_q.size() - int'(pop);
        ereq = (used < DEPTH);
        ehaz = !(ereq && gnt_en);
        chk("id_valid", 32'(id_valid), 32'(ev));
        chk("id_pc", id_pc, epc);
        chk("id_inst", id_inst, einst);
        chk("imem_req", 32'(imem_req), 32'(ereq));
        chk("pc_hazarded", 32'(pc_hazarded), 32'(ehaz));
        chk("imem_addr", imem_addr, curr_pc);
        if (watch && id_valid && first_cyc < 0) begin
            first_cyc  = cyc;
            first_pc   = id_pc;
            first_inst = id_inst;
        end
        if (pc_hazarded) haz_cnt++;
        last_haz   = pc_hazarded;
        last_id_pc = id_pc;
        @(posedge clk);
        if (ev) {m_last_pc, m_last_inst} = m_q[0];
        if (pop && !fl) void'(m_q.pop_front());
        if (imem_rvalid) begin
            e = m_fly.pop_front();
            void'(m_due.pop_front());
            void'(m_mem.pop_front());
            if (!fl && !e[32]) m_q.push_back({e[31:0], imem_rdata});
        end
        if (fl) begin
            m_q.delete();
            if (!m_prev_flush) begin
                foreach (m_fly[i]) m_fly[i][32] = 1'b1;
            end
        end
        if (ereq && gnt_en) begin
            m_fly.push_back({1'b0, curr_pc});
            m_mem.push_back(word_of(curr_pc));
            m_due.push_back(cyc + lat);
            pc_reg = curr_pc + 32'd4;
        end
        m_prev_flush = fl;
        cyc++;
        #1;
    endtask

    task automatic arm_watch();
        watch     = 1'b1;
        first_cyc = -1;
        first_pc  = 32'hFFFF_FFFF;
        first_inst = 32'hFFFF_FFFF;
    endtask

    initial begin
        logic [31:0] exp_rst_inst;
        int          fcyc;
`ifdef IF_NOP_INJECT_EN
        exp_rst_inst = 32'h0000_0013;
`else
        exp_rst_inst = 32'h0;
`endif
        rst = 1'b0; curr_pc = '0; pipelineFlush = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
        lat = 1; gnt_en = 1'b1; rdy = 1'b1; fl = 1'b0; fl_tgt = '0;
        watch = 1'b0; first_cyc = -1; haz_cnt = 0; last_haz = 1'b0; last_id_pc = '0;
        model_clear();

        #12;
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_pc_hazarded", 32'(pc_hazarded), 32'd1);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, exp_rst_inst);
        @(posedge clk); #1;
        rst = 1'b1;
        cyc = 0;

        // streaming from PC 0 with 1-cycle memory
        arm_watch();
        haz_cnt = 0;
        cycle();
        haz_cnt = 0;
        repeat (7) cycle();
        chk("stream_first_valid_cycle", 32'(first_cyc), 32'd2);
        chk("stream_first_pc", first_pc, 32'h0);
        chk("stream_first_inst", first_inst, 32'h1000_0000);
        chk("stream_hazard_cycles", 32'(haz_cnt), 32'd0);
        watch = 1'b0;

        // decode stall for 5 cycles
        rdy = 1'b0; haz_cnt = 0;
        repeat (5) cycle();
        chk("stall_hazard_cycles", 32'(haz_cnt), 32'd5);
        chk("stall_head_pc", last_id_pc, 32'h18);
        rdy = 1'b1;
        repeat (6) cycle();

        // two requests in flight, then redirect to 0x100
        lat = 2;
        repeat (2) cycle();
        fl = 1'b1; fl_tgt = 32'h100;
        cycle();
        fl = 1'b0;
        arm_watch();
        repeat (8) cycle();
        chk("flush_target_pc", first_pc, 32'h100);
        chk("flush_target_inst", first_inst, 32'h1000_0100);
        watch = 1'b0;

        // flush coincident with a stale response and a target grant
        lat = 1;
        repeat (6) cycle();
        fl = 1'b1; fl_tgt = 32'h200;
        fcyc = cyc;
        cycle();
        chk("coincident_flush_grant", 32'(last_haz), 32'd0);
        fl = 1'b0;
        arm_watch();
        repeat (6) cycle();
        chk("coincident_target_pc", first_pc, 32'h200);
        chk("coincident_latency", 32'(first_cyc - fcyc), 32'd2);
        watch = 1'b0;

        // grant withheld for 3 cycles
        gnt_en = 1'b0; haz_cnt = 0;
        repeat (3) cycle();
        chk("withheld_hazard_cycles", 32'(haz_cnt), 32'd3);
        gnt_en = 1'b1;
        repeat (6) cycle();

        // fill the queue, then reset mid-cycle
        rdy = 1'b0;
        repeat (4) cycle();
        chk("full_before_reset_valid", 32'(id_valid), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_id_valid", 32'(id_valid), 32'd0);
        chk("midrst_id_inst", id_inst, exp_rst_inst);
        chk("midrst_id_pc", id_pc, 32'h0);
        chk("midrst_imem_req", 32'(imem_req), 32'd0);
        chk("midrst_pc_hazarded", 32'(pc_hazarded), 32'd1);
        model_clear();
        rdy = 1'b1; lat = 1;
        @(posedge clk); #1;
        rst = 1'b1;
        cyc = 0;
        arm_watch();
        repeat (6) cycle();
        chk("post_reset_first_cycle", 32'(first_cyc), 32'd2);
        chk("post_reset_first_pc", first_pc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
